// File: rtl/ext_mailbox_pkg.sv
// Shared constants and page decode for the EXT bus mailbox.
package ext_mailbox_pkg;

    // Page numbers, taken from ext_addr[15:8]
    localparam logic [7:0] PAGE_RX   = 8'h00;
    localparam logic [7:0] PAGE_TX   = 8'h01;
    localparam logic [7:0] PAGE_STAT = 8'h02;
    localparam logic [7:0] PAGE_CTRL = 8'h03;

    // Offsets inside the status page
    localparam logic [7:0] STAT_TX_COUNT = 8'h00;
    localparam logic [7:0] STAT_RX_FREE  = 8'h01;
    localparam logic [7:0] STAT_FLAGS    = 8'h02;

    // Offset of the control register and its bit positions
    localparam logic [7:0] CTRL_OFFSET   = 8'h00;
    localparam int         CTRL_TX_FLUSH = 0;
    localparam int         CTRL_RX_FLUSH = 1;

    // Value driven on ext_din when there is nothing meaningful to read
    localparam logic [15:0] EXT_IDLE = 16'hFFFF;

    typedef enum logic [2:0] {
        SEL_RX,
        SEL_TX,
        SEL_STAT,
        SEL_CTRL,
        SEL_NONE
    } page_sel_e;

    function automatic page_sel_e decode_page(input logic [7:0] page);
        page_sel_e sel;
        case (page)
            PAGE_RX:   sel = SEL_RX;
            PAGE_TX:   sel = SEL_TX;
            PAGE_STAT: sel = SEL_STAT;
            PAGE_CTRL: sel = SEL_CTRL;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ext_mailbox_fifo.sv
// Show-ahead FIFO: synchronous-read RAM followed by a head register.
// A word becomes visible at the head two cycles after its push; once a word
// is stored, popping presents the following stored word on the next cycle.
module ext_mailbox_fifo
    import ext_mailbox_pkg::*;
#(
    parameter int AW = 8,
    parameter int W  = 16
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  count
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW:0]   DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW-1:0] rd_addr_p0;
    logic [AW:0]   stored_left_p0;
    logic [W-1:0]  head_p1;
    logic          vld_p1;
    logic          pop_ok;
    logic          push_ok;

    // A pop only counts when a word is visible; a push into a full FIFO is
    // accepted only if a pop frees a slot in the same cycle. Flush wins.
    assign pop_ok  = pop & vld_p1 & ~flush;
    assign push_ok = push & ~flush & ((count_q != DEPTH_C) | pop_ok);

    // Stage p0: address the RAM with the head position after this cycle's pop
    assign rd_addr_p0     = pop_ok ? (rd_ptr + PTR_ONE) : rd_ptr;
    assign stored_left_p0 = count_q - (pop_ok ? CNT_ONE : '0);

    // RAM write port
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Stage p1: head register, sampled from the RAM every cycle
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            head_p1 <= '0;
        end else begin
            head_p1 <= mem[rd_addr_p0];
        end
    end

    // Pointers, occupancy and head validity; words pushed this cycle are not
    // yet readable, so validity follows the words stored before this edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_p1  <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_p1  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_addr_p0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            vld_p1 <= (stored_left_p0 != '0);
        end
    end

    assign head  = head_p1;
    assign empty = ~vld_p1;
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;

endmodule

// File: rtl/ext_mailbox.sv
// EXT bus mailbox: HPS->core RX FIFO, core->HPS TX FIFO, status and control
// pages. Optional status page and sticky error flags: EXT_MAILBOX_STATUS_EN.
module ext_mailbox
    import ext_mailbox_pkg::*;
#(
    parameter int RX_AW = 8,
    parameter int TX_AW = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [15:0]      ext_addr,
    input  logic [15:0]      ext_dout,
    input  logic             ext_wr,
    input  logic             ext_rd,
    output logic [15:0]      ext_din,
    output logic [7:0]       ext_req,
    input  logic             rx_rd,
    output logic [15:0]      rx_data,
    output logic             rx_empty,
    output logic [RX_AW:0]   rx_count,
    input  logic             tx_wr,
    input  logic [15:0]      tx_data,
    output logic             tx_full,
    output logic [TX_AW:0]   tx_count
);

    page_sel_e   sel;
    logic [7:0]  offset;
    logic        rx_push;
    logic        tx_pop;
    logic        ctrl_wr;
    logic        rx_flush;
    logic        tx_flush;
    logic        rx_full;
    logic        tx_empty;
    logic [15:0] tx_head;
    logic [15:0] stat_data;
    logic        status_req;

    assign sel     = decode_page(ext_addr[15:8]);
    assign offset  = ext_addr[7:0];
    assign rx_push = ext_wr & (sel == SEL_RX);
    assign tx_pop  = ext_rd & (sel == SEL_TX);
    assign ctrl_wr = ext_wr & (sel == SEL_CTRL) & (offset == CTRL_OFFSET);
    assign tx_flush = ctrl_wr & ext_dout[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr & ext_dout[CTRL_RX_FLUSH];

    ext_mailbox_fifo #(.AW(RX_AW), .W(16)) u_rx_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .flush   (rx_flush),
        .push    (rx_push),
        .din     (ext_dout),
        .pop     (rx_rd),
        .head    (rx_data),
        .empty   (rx_empty),
        .full    (rx_full),
        .count   (rx_count)
    );

    ext_mailbox_fifo #(.AW(TX_AW), .W(16)) u_tx_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .flush   (tx_flush),
        .push    (tx_wr),
        .din     (tx_data),
        .pop     (tx_pop),
        .head    (tx_head),
        .empty   (tx_empty),
        .full    (tx_full),
        .count   (tx_count)
    );

`ifdef EXT_MAILBOX_STATUS_EN
    localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};

    logic rx_ovf;
    logic tx_urun;
    logic rx_drop;
    logic tx_under;

    // A bridge push is lost only when RX is full and the core is not popping
    assign rx_drop  = rx_push & rx_full & ~(rx_rd & ~rx_empty);
    assign tx_under = tx_pop & tx_empty;

    // Sticky error flags, cleared by the matching flush bit
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rx_ovf  <= 1'b0;
            tx_urun <= 1'b0;
        end else begin
            if (rx_flush) begin
                rx_ovf <= 1'b0;
            end else if (rx_drop) begin
                rx_ovf <= 1'b1;
            end
            if (tx_flush) begin
                tx_urun <= 1'b0;
            end else if (tx_under) begin
                tx_urun <= 1'b1;
            end
        end
    end

    // Status page read mux
    always_comb begin
        stat_data = 16'h0000;
        case (offset)
            STAT_TX_COUNT: stat_data = 16'(tx_count);
            STAT_RX_FREE:  stat_data = 16'(RX_DEPTH - rx_count);
            STAT_FLAGS:    stat_data = {14'b0, tx_urun, rx_ovf};
            default:       stat_data = 16'h0000;
        endcase
    end

    assign status_req = rx_ovf | tx_urun;
`else
    logic stat_unused;

    assign stat_unused = rx_full;
    assign stat_data   = EXT_IDLE;
    assign status_req  = 1'b0;
`endif

    // Bridge read data: combinational from the address and registered state
    always_comb begin
        ext_din = EXT_IDLE;
        case (sel)
            SEL_TX:   ext_din = tx_empty ? EXT_IDLE : tx_head;
            SEL_STAT: ext_din = stat_data;
            default:  ext_din = EXT_IDLE;
        endcase
    end

    assign ext_req = {5'b0, rx_empty, status_req, ~tx_empty};

endmodule
